// File: rtl/cdc_mux_sync_rx.sv
// Destination-side mux-recirculation CDC receiver: N-flop sync on en, qualified capture, ready/valid out.
// Optional feature macro CDC_MUX_SYNC_RX_OVERRUN_EN: keep the pending word and flag overrun on back-pressure.
`timescale 1ns/1ps
module cdc_mux_sync_rx #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned MODE   = 0
) (
    input  logic             clkb,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_sync,
    output logic             valid,
    output logic             ack,
    output logic             overrun
);
    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    logic [STAGES-1:0] sync_q;
    logic              en_d_q;
    logic              evt;
    state_e            state_q;
    logic [WIDTH-1:0]  data_q;
`ifdef CDC_MUX_SYNC_RX_OVERRUN_EN
    logic              overrun_q;
`endif

    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            en_d_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], en};
            en_d_q <= sync_q[STAGES-1];
        end
    end

    always_comb begin
        evt = 1'b0;
        if (MODE == 0) begin
            evt = sync_q[STAGES-1] & ~en_d_q;
        end else begin
            evt = sync_q[STAGES-1] ^ en_d_q;
        end
    end

    // data is only ever sampled on an event; otherwise data_q recirculates.
    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StEmpty;
            data_q    <= '0;
`ifdef CDC_MUX_SYNC_RX_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (evt) begin
                        data_q  <= data;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        if (evt) begin
                            data_q <= data;
                        end else begin
                            state_q <= StEmpty;
                        end
                    end else if (evt) begin
`ifdef CDC_MUX_SYNC_RX_OVERRUN_EN
                        overrun_q <= 1'b1;
`else
                        data_q <= data;
`endif
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign data_sync = data_q;
    assign valid     = (state_q == StFull);
    assign ack       = en_d_q;
`ifdef CDC_MUX_SYNC_RX_OVERRUN_EN
    assign overrun   = overrun_q;
`else
    assign overrun   = 1'b0;
`endif

endmodule

// File: doc/cdc_mux_sync_rx.md
# cdc_mux_sync_rx

Destination-side receiver for multi-bit clock-domain crossing with a mux-recirculation scheme: a control signal `en` from the source domain passes through an N-flop synchronizer, and the `data` bus (held stable by the source) is captured into a recirculating register only on a qualified `en` event. This is the parametrised successor of the fixed 8-bit, 2-flop, level-only mux synchronizer. It adds configurable width and sync depth, level-handshake or toggle event modes, an `ack` return for four-phase handshaking, and a ready/valid output stage. The block sits entirely in the `clkb` domain, between the asynchronous source interface and the destination consumer.

## Interface
- `WIDTH`, 8, data bus width (≥1)
- `STAGES`, 2, synchronizer flops on `en` (≥2)
- `MODE`, 0, 0 = level/four-phase (rising edge of synced `en` is the event); 1 = toggle (any transition of synced `en` is the event)

- `clkb`  in  1  destination clock; single clock of the block
- `rstn`  in  1  asynchronous, active-low reset
- `en`  in  1  asynchronous qualifier from source domain
- `data`  in  WIDTH  asynchronous bus; source holds it stable from the `en` change until `ack` reflects it
- `out_ready`  in  1  consumer accepts `data_sync` this cycle
- `data_sync`  out  WIDTH  captured word; holds between captures
- `valid`  out  1  `data_sync` holds an unconsumed word
- `ack`  out  1  registered synced `en` (`en_d`); returned to source for handshake
- `overrun`  out  1  sticky: event arrived while a word was pending

## Operation
- Sync chain `s[0..STAGES-1]` samples `en`. `en_d` <= `s[STAGES-1]`.
- Event: MODE 0 `s[STAGES-1] & ~en_d`; MODE 1 `s[STAGES-1] ^ en_d`.
- `data` is never sampled except on an event cycle. `data_sync` recirculates otherwise.
- Output stage states: EMPTY (`valid`=0) and FULL (`valid`=1).
  - EMPTY + event -> capture `data` into `data_sync`, go to FULL.
  - FULL + `out_ready` + no event -> EMPTY.
  - FULL + `out_ready` + event -> capture, stay FULL (consume and reload in the same cycle; not an overrun).
  - FULL + !`out_ready` + event -> overrun case (see Configuration).
- MODE 0 handshake: the source raises `en` with `data` and waits for `ack`=1, then drops `en` and waits for `ack`=0 before the next word. Falling edges generate no event.
- MODE 1: the source toggles `en` once per word and waits for `ack`==`en` before the next toggle.
- Reset (asynchronous, any time, including mid-transfer) clears `s`, `en_d`, `data_sync`, `valid`, `ack` and `overrun` to 0. In-flight data is lost. In MODE 1 the source must also reset its toggle to 0; an `en`=1 seen after reset release produces one event.

## Timing
- Every output is a flop; there is no combinational path from any input to any output.
- `en` change settled before `clkb` edge k: `s[STAGES-1]` updates at edge k+STAGES-1, the event is seen in the following cycle, and `data_sync`/`valid`/`ack` update at edge k+STAGES. Latency is STAGES+1 edges, plus one edge of metastability uncertainty.
- `valid` drops on the edge where `out_ready`=1 is sampled, unless a simultaneous event reloads it.
- `overrun`, once set, stays 1 until reset.
- The source must hold `data` stable from its `en` change until it observes `ack`. A violation gives undefined `data_sync`.
- A MODE 0 `en` pulse shorter than one `clkb` period may be lost. The four-phase handshake is the only guarantee of delivery.

## Configuration
- `CDC_MUX_SYNC_RX_OVERRUN_EN` defined: on FULL + !`out_ready` + event, the pending word is kept, the new word is dropped, and `overrun` is set to 1.
- Not defined: the new word overwrites `data_sync`, `valid` stays 1, and `overrun` is tied to 0.

## Test plan
- Reset: `rstn`=0 with `en`=1 and `data`=8'hA5 -> `data_sync`=0, `valid`=0, `ack`=0, `overrun`=0 for as long as reset is held.
- MODE 0, STAGES=2, `clkb` 3 ns: `en`↑ with `data`=8'h55 and `out_ready`=1 -> `data_sync`=8'h55 with a 1-cycle `valid` within 3–4 edges. `ack`=1 in the same cycle. `en`↓ -> `ack`=0 three edges later, no new `valid`.
- MODE 0 handshake sequence 8'h55, 8'h00, 8'hFF -> exactly three captures, in order, with no loss.
- MODE 1, STAGES=3, WIDTH=16: toggle `en` with 16'h1234, then 16'hBEEF -> two captures, each 4–5 edges after its toggle. `ack` tracks `en`.
- Back-pressure with `out_ready`=0 and 8'h11 then 8'h22: with the macro, `data_sync`=8'h11 and `overrun`=1; without it, `data_sync`=8'h22 and `overrun`=0. An event in the same cycle as `out_ready`=1 leaves `overrun`=0 and loads the new word.
- Assert `rstn` low between the `en`↑ and `valid` -> all outputs return to 0 and no `valid` pulse appears after reset release while `en` is held at 0.
